// File: rtl/uart_alu_ctrl_pkg.sv
// rtl/uart_alu_ctrl_pkg.sv - shared widths, state encodings and ALU opcodes for the frame sequencer
package uart_alu_ctrl_pkg;

    localparam int DEF_N_BIT  = 8;
    localparam int DEF_OP_BIT = 6;

    localparam logic [2:0] ST_GET_A  = 3'd0;
    localparam logic [2:0] ST_GET_B  = 3'd1;
    localparam logic [2:0] ST_GET_OP = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;

    typedef enum logic [2:0] {
        GET_A  = ST_GET_A,
        GET_B  = ST_GET_B,
        GET_OP = ST_GET_OP,
        EXEC   = ST_EXEC,
        SEND   = ST_SEND
    } state_t;

endpackage

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - pops A/B/opcode from the rx FIFO, latches the ALU result and pushes it to the tx FIFO
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int N_BIT  = DEF_N_BIT,
    parameter int OP_BIT = DEF_OP_BIT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rx_empty,
    input  logic [N_BIT-1:0]  r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [N_BIT-1:0]  w_data,
    output logic              wr_uart,
    output logic [N_BIT-1:0]  alu_a,
    output logic [N_BIT-1:0]  alu_b,
    output logic [OP_BIT-1:0] alu_op,
    input  logic [N_BIT-1:0]  alu_result,
    output logic              busy,
    output logic [N_BIT-1:0]  leds
);

    state_t           state;
    state_t           state_nxt;
    logic [N_BIT-1:0] result_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= GET_A;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            result_q <= '0;
            leds     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                GET_A:   if (!rx_empty) alu_a <= r_data;
                GET_B:   if (!rx_empty) alu_b <= r_data;
                GET_OP:  if (!rx_empty) alu_op <= r_data[OP_BIT-1:0];
                EXEC:    result_q <= alu_result;
                SEND:    if (!tx_full) leds <= result_q;
                default: ;
            endcase
        end
    end

    // rd_uart is Mealy on rx_empty; gating with RESET keeps it low while reset is held
    always_comb begin
        state_nxt = state;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        case (state)
            GET_A: begin
                rd_uart = ~rx_empty & RESET;
                if (!rx_empty) state_nxt = GET_B;
            end
            GET_B: begin
                rd_uart = ~rx_empty & RESET;
                if (!rx_empty) state_nxt = GET_OP;
            end
            GET_OP: begin
                rd_uart = ~rx_empty & RESET;
                if (!rx_empty) state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = SEND;
            end
            SEND: begin
                wr_uart = ~tx_full;
                if (!tx_full) state_nxt = GET_A;
            end
            default: begin
                state_nxt = GET_A;
            end
        endcase
    end

    assign w_data = result_q;
    assign busy   = (state != GET_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - directed scoreboard bench for the uart_alu_ctrl frame sequencer
module tb_uart_alu_ctrl;
    import uart_alu_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic [7:0] leds;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int pops = 0;
    int pushes = 0;
    logic [7:0] rxq[$];
    logic [7:0] sbq[$];
    int push_cyc[$];

    uart_alu_ctrl #(.N_BIT(8), .OP_BIT(6)) dut (
        .CLK(CLK), .RESET(RESET), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .leds(leds)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic refresh_rx();
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        refresh_rx();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_pushes(input int target, input int budget);
        int k;
        k = 0;
        while (pushes < target && k < budget) begin
            tick(1);
            k++;
        end
        if (pushes < target) check("push_timeout", pushes, target);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k;
        k = 0;
        while (pops < target && k < budget) begin
            tick(1);
            k++;
        end
        if (pops < target) check("pop_timeout", pops, target);
    endtask

    // FIFO model: pop on the edge where rd_uart is asserted
    always @(posedge CLK) begin
        cyc++;
        if (rd_uart && rxq.size() > 0) void'(rxq.pop_front());
        #1 refresh_rx();
    end

    always @(negedge CLK) begin
        if (RESET) begin
            if (rd_uart) begin
                pops++;
                check("rd_while_empty", rx_empty, 1'b0);
            end
            if (wr_uart) begin
                pushes++;
                push_cyc.push_back(cyc);
                check("rd_wr_overlap", rd_uart, 1'b0);
                if (sbq.size() == 0) check("unexpected_push", 1, 0);
                else check("w_data", w_data, sbq.pop_front());
            end
        end
    end

    initial begin
        int p0;
        int c0;
        int n0;

        // reset state
        #2;
        check("rst_rd", rd_uart, 0);
        check("rst_wr", wr_uart, 0);
        check("rst_busy", busy, 0);
        check("rst_leds", leds, 0);
        check("rst_a", alu_a, 0);
        check("rst_op", alu_op, 0);
        tick(2);
        RESET = 1'b1;
        tick(2);

        // basic add
        p0 = pops;
        c0 = cyc;
        n0 = push_cyc.size();
        sbq.push_back(8'h08);
        push_rx(8'h05); push_rx(8'h03); push_rx(8'h20);
        wait_pushes(1, 30);
        tick(1);
        check("add_pops", pops - p0, 3);
        check("add_latency", push_cyc[n0] - c0, 4);
        check("add_leds", leds, 8'h08);
        check("add_busy", busy, 0);

        // back-to-back frames
        p0 = pops;
        n0 = push_cyc.size();
        sbq.push_back(8'h0C);
        sbq.push_back(8'hFF);
        push_rx(8'h10); push_rx(8'h04); push_rx(8'h22);
        push_rx(8'hF0); push_rx(8'h0F); push_rx(8'h25);
        wait_pushes(3, 40);
        tick(3);
        check("b2b_pops", pops - p0, 6);
        check("b2b_spacing", push_cyc[n0+1] - push_cyc[n0], 5);
        check("b2b_leds", leds, 8'hFF);

        // starved receive
        sbq.push_back(8'h00);
        push_rx(8'hFF);
        tick(20);
        check("starve_busy", busy, 1);
        push_rx(8'h01);
        tick(20);
        push_rx(8'h20);
        wait_pushes(4, 30);
        tick(1);
        check("starve_leds", leds, 8'h00);

        // tx backpressure
        tx_full = 1'b1;
        n0 = pushes;
        sbq.push_back(8'h1E);
        push_rx(8'h30); push_rx(8'h12); push_rx(8'h22);
        tick(5);
        for (int i = 0; i < 10; i++) begin
            check("bp_no_wr", wr_uart, 0);
            check("bp_w_data", w_data, 8'h1E);
            tick(1);
        end
        check("bp_held_pushes", pushes - n0, 0);
        tx_full = 1'b0;
        tick(3);
        check("bp_one_push", pushes - n0, 1);
        check("bp_leds", leds, 8'h1E);

        // reset mid-frame after the second pop
        p0 = pops;
        push_rx(8'h07); push_rx(8'h02);
        wait_pops(p0 + 2, 20);
        check("mid_b", alu_b, 8'h02);
        #2;
        RESET = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_a", alu_a, 0);
        check("mid_rst_b", alu_b, 0);
        check("mid_rst_leds", leds, 0);
        check("mid_rst_rd", rd_uart, 0);
        check("mid_rst_wr", wr_uart, 0);
        tick(2);
        RESET = 1'b1;
        tick(1);
        sbq.push_back(8'h08);
        push_rx(8'h09); push_rx(8'h01); push_rx(8'h22);
        wait_pushes(6, 30);
        tick(1);
        check("mid_leds", leds, 8'h08);

        // opcode masking
        sbq.push_back(8'h0C);
        push_rx(8'h3C); push_rx(8'h0F); push_rx(8'hE4);
        wait_pushes(7, 30);
        tick(1);
        check("mask_op", alu_op, 6'h24);
        check("mask_leds", leds, 8'h0C);
        check("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame sequencer between the UART core's FIFOs and the combinational ALU. It pops three bytes (operand A, operand B, opcode) from the receive FIFO and presents them to the ALU. It captures the ALU result and pushes it into the transmit FIFO, then waits for the next frame. It replaces the loopback wiring in the board-level top and mirrors the last result on the LEDs.

## Interface
Parameters:
- `N_BIT`, 8: data width of UART words, operands and result.
- `OP_BIT`, 6: ALU opcode width; the low `OP_BIT` bits of the opcode byte are used.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`, in, 1: system clock, rising edge.
- `RESET`, in, 1: asynchronous, active-low reset.
- `rx_empty`, in, 1: receive FIFO empty.
- `r_data`, in, `N_BIT`: receive FIFO head word; valid while `rx_empty`=0.
- `rd_uart`, out, 1: receive FIFO pop strobe.
- `tx_full`, in, 1: transmit FIFO full.
- `w_data`, out, `N_BIT`: transmit word.
- `wr_uart`, out, 1: transmit FIFO push strobe.
- `alu_a`, out, `N_BIT`: operand A, registered.
- `alu_b`, out, `N_BIT`: operand B, registered.
- `alu_op`, out, `OP_BIT`: opcode, registered.
- `alu_result`, in, `N_BIT`: combinational ALU output.
- `busy`, out, 1: high whenever state ≠ GET_A.
- `leds`, out, `N_BIT`: last transmitted result.

## Operation
- FSM states: GET_A, GET_B, GET_OP, EXEC, SEND.
- GET_A, GET_B, GET_OP: wait while `rx_empty`=1. When `rx_empty`=0 in the same cycle:
  - `rd_uart`=1 (Mealy output, one cycle per byte).
  - `r_data` is loaded into the matching register.
  - Advance to the next state.
  - Exactly one pop per byte. Never pop while empty.
- EXEC: one cycle. Load `alu_result` into the result register (the operands have been stable for at least one cycle). Go to SEND.
- SEND: `wr_uart` = ~`tx_full` and `w_data` = result register.
  - On the push cycle, `leds` ← result and the FSM returns to GET_A.
  - While `tx_full`=1, hold SEND with `wr_uart`=0. `w_data` stays stable.
- `rd_uart` and `wr_uart` are never high in the same cycle.
- No rx reads happen during EXEC or SEND. Bytes arriving then stay queued in the FIFO.
- Width rules:
  - `alu_op` = `r_data[OP_BIT-1:0]`; the upper bits are ignored.
  - The result is truncated to `N_BIT` by the ALU. There is no carry out.
- Reset (`RESET`=0, any time):
  - State → GET_A.
  - `alu_a`, `alu_b`, `alu_op`, result register and `leds` → 0.
  - `rd_uart`, `wr_uart` and `busy` → 0.
  - A partially received frame is discarded. Bytes already popped are lost; bytes still in the FIFO are not flushed.

## Timing
- Byte pops occur in the same cycle `rx_empty` falls, at the earliest.
- Third pop at cycle t: EXEC at t+1, earliest `wr_uart` at t+2.
- Minimum frame time with a full rx FIFO and free tx FIFO: 5 cycles (3 pops, EXEC, SEND).
- `leds` updates on the edge ending the push cycle.
- `busy` rises on the edge after the first pop. It falls on the edge after the push.

## Structure
- The shared package/header holds:
  - State encodings (3-bit localparams `ST_GET_A`…`ST_SEND`).
  - Default `N_BIT`/`OP_BIT`.
  - The opcode constants used by the ALU and the bench (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25).
- Single flat module, no sub-module:
  - One sequential block for state and registers (async clear on `negedge RESET`).
  - One combinational block for next-state, `rd_uart` and `wr_uart`.
- Top integration: `uart_alu_ctrl` sits between `UART` and the ALU.

## Test plan
- Basic add:
  - Stimulus: queue 0x05, 0x03, 0x20 with a model ALU.
  - Required: three single-cycle `rd_uart` pulses; then `wr_uart` once with `w_data`=0x08; `leds`=0x08; `busy` low afterwards.
- Back-to-back frames:
  - Stimulus: pre-load 6 bytes (0x10, 0x04, 0x22, 0xF0, 0x0F, 0x25).
  - Required: pushes of 0x0C then 0xFF, each 5 cycles apart; no extra pops.
- Starved receive:
  - Stimulus: bytes arrive 20 cycles apart (0xFF, 0x01, 0x20).
  - Required: no `rd_uart` while `rx_empty`=1; result 0x00 (truncated); `rd_uart` and `wr_uart` never high together.
- Tx backpressure:
  - Stimulus: hold `tx_full`=1 for 10 cycles in SEND.
  - Required: `wr_uart`=0 and `w_data` stable throughout; exactly one push in the cycle `tx_full` drops.
- Reset mid-frame:
  - Stimulus: assert `RESET`=0 after the second pop of frame 0x07, 0x02, 0x22, then release.
  - Required: all outputs 0 immediately (asynchronously); the next three bytes 0x09, 0x01, 0x22 produce 0x08.
- Opcode masking:
  - Stimulus: opcode byte 0xE4.
  - Required: `alu_op`=6'h24 (AND).
